// File: rtl/avr_mul_unit.sv
// avr_mul_unit: multi-cycle 8x8 multiplier for AVR MUL/MULS/MULSU/FMUL with two-cycle R1:R0 write-back
//   clk, rst            clock, asynchronous active-high reset
//   start, op, opA, opB request, operation select (00 MUL, 01 MULS, 10 MULSU, 11 FMUL), Rd and Rr values
//   busy                high from the cycle after an accepted start through the final write-back cycle
//   wbEn, wbAddr, wbData register-file write port (low byte in WB_LO, high byte in WB_HI)
//   done                one-cycle pulse alongside the high-byte write
//   flagC, flagZ        carry and zero of the last completed operation
module avr_mul_unit #(
    parameter logic [4:0] LO_ADDR = 5'd0,
    parameter logic [4:0] HI_ADDR = 5'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] opA,
    input  logic [7:0] opB,
    output logic       busy,
    output logic       wbEn,
    output logic [4:0] wbAddr,
    output logic [7:0] wbData,
    output logic       done,
    output logic       flagC,
    output logic       flagZ
);
    typedef enum logic [2:0] {IDLE, MULT, FIX, WB_LO, WB_HI} state_t;

    state_t      state_q;
    logic [7:0]  a_q, b_q;
    logic [1:0]  op_q;
    logic        neg_q;
    logic [2:0]  cnt_q;
    logic [15:0] p_q;
    logic        c_q, z_q;
    logic        busy_q, wb_en_q, done_q, flag_c_q, flag_z_q;
    logic [4:0]  wb_addr_q;
    logic [7:0]  wb_data_q;

    logic        sa, sb;
    logic [7:0]  a_d, b_d;
    logic [15:0] add_d, neg_p, fix_p;

    // Operands are reduced to magnitudes at latch time so MULT only ever sees unsigned values;
    // the magnitude of 0x80 is 0x80, which is still a valid unsigned byte.
    always_comb begin
        sa    = (op == 2'b01 || op == 2'b10) && opA[7];
        sb    = (op == 2'b01) && opB[7];
        a_d   = sa ? (~opA + 8'd1) : opA;
        b_d   = sb ? (~opB + 8'd1) : opB;
        add_d = b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0;
        neg_p = neg_q ? (~p_q + 16'd1) : p_q;
        fix_p = (op_q == 2'b11) ? {neg_p[14:0], 1'b0} : neg_p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            p_q       <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            done_q    <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    op_q    <= op;
                    neg_q   <= sa ^ sb;
                    p_q     <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= MULT;
                end
                MULT: begin
                    p_q     <= p_q + add_d;
                    cnt_q   <= cnt_q + 3'd1;
                    state_q <= (cnt_q == 3'd7) ? FIX : MULT;
                end
                // Outputs are registered, so the low-byte write is launched here to appear in WB_LO.
                // Carry is taken after negation but before the FMUL shift; zero after the shift.
                FIX: begin
                    p_q       <= fix_p;
                    c_q       <= neg_p[15];
                    z_q       <= (fix_p == 16'd0);
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= LO_ADDR;
                    wb_data_q <= fix_p[7:0];
                    state_q   <= WB_LO;
                end
                WB_LO: begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= HI_ADDR;
                    wb_data_q <= p_q[15:8];
                    done_q    <= 1'b1;
                    flag_c_q  <= c_q;
                    flag_z_q  <= z_q;
                    state_q   <= WB_HI;
                end
                WB_HI: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign wbEn   = wb_en_q;
    assign wbAddr = wb_addr_q;
    assign wbData = wb_data_q;
    assign done   = done_q;
    assign flagC  = flag_c_q;
    assign flagZ  = flag_z_q;
endmodule

// File: tb/tb_avr_mul_unit.sv
// tb_avr_mul_unit: scoreboard bench for avr_mul_unit with directed, hand-computed vectors
module tb_avr_mul_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] opA, opB;
    logic       busy, wbEn, done, flagC, flagZ;
    logic [4:0] wbAddr;
    logic [7:0] wbData;

    avr_mul_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .done(done), .flagC(flagC), .flagZ(flagZ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         wb_cnt = 0;
    int         done_cnt = 0;
    logic       lo_seen = 1'b0;
    logic [7:0] lo_got = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pairs each low-byte write with the following done cycle and scores against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wbEn) wb_cnt++;
            if (wbEn && !done) begin
                chk("lo_addr", 32'(wbAddr), 32'd0);
                lo_got  = wbData;
                lo_seen = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("lo_written", 32'(lo_seen), 32'd1);
                    chk("lo_data", 32'(lo_got), 32'(e.lo));
                    chk("hi_en", 32'(wbEn), 32'd1);
                    chk("hi_addr", 32'(wbAddr), 32'd1);
                    chk("hi_data", 32'(wbData), 32'(e.hi));
                    chk("flagC", 32'(flagC), 32'(e.c));
                    chk("flagZ", 32'(flagZ), 32'(e.z));
                    chk("busy_at_done", 32'(busy), 32'd1);
                    chk("latency", 32'(cyc - e.cyc), 32'd11);
                end
                lo_seen = 1'b0;
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] lo, input logic [7:0] hi, input logic c, input logic z);
        exp_t e;
        e.lo = lo; e.hi = hi; e.c = c; e.z = z; e.cyc = cyc;
        q.push_back(e);
        op = o; opA = a; opB = b; start = 1'b1;
    endtask

    task automatic finish_op();
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] lo, input logic [7:0] hi, input logic c, input logic z);
        launch(o, a, b, lo, hi, c, z);
        finish_op();
    endtask

    initial begin
        int wb0, d0;
        rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb", {22'd0, wbEn, wbAddr, 1'b0, done, flagC, flagZ}, 32'd0);
        chk("rst_data", 32'(wbData), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0);
        run(2'b01, 8'h80, 8'h7F, 8'h80, 8'hC0, 1'b1, 1'b0);
        run(2'b01, 8'h80, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0);
        run(2'b10, 8'hFF, 8'h02, 8'hFE, 8'hFF, 1'b1, 1'b0);
        run(2'b10, 8'h02, 8'hFF, 8'hFE, 8'h01, 1'b0, 1'b0);
        run(2'b11, 8'h80, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0);
        run(2'b11, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1);

        // Operands and op scrambled after the start cycle; starts at cycles 4 and 11 must be ignored.
        wb0 = wb_cnt; d0 = done_cnt;
        launch(2'b00, 8'h03, 8'h05, 8'h0F, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            opA   = 8'(i * 29 + 1);
            opB   = ~opA;
            op    = 2'(i);
            start = (i == 4 || i == 11);
        end
        @(negedge clk);
        chk("single_op_wb", 32'(wb_cnt - wb0), 32'd2);
        chk("single_op_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_at_12", 32'(busy), 32'd0);
        run(2'b00, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0, 1'b0);

        // Abort: flags are nonzero before this (last op was clean, so set them with a carry first).
        run(2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0);
        op = 2'b00; opA = 8'hFF; opB = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_quiet", {29'd0, busy, wbEn, done}, 32'd0);
        end
        chk("abort_flags", {30'd0, flagC, flagZ}, 32'd0);
        run(2'b00, 8'h02, 8'h03, 8'h06, 8'h00, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
